// File: rtl/snpu_trng_pkg.sv
// Shared types, default sizing and width helpers for the SNPU entropy harvester.
package snpu_trng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2,
    FAIL = 2'd3
  } trng_state_e;

  localparam int N_SRC_DEF       = 8;
  localparam int OUT_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int SAMPLE_DIV_DEF  = 8;
  localparam int REP_LIMIT_DEF   = 16;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/snpu_entropy_cell.sv
// One NAND2 cross-coupled latch excited by G (S=R=G), followed by a reset-to-zero synchroniser.
module snpu_entropy_cell #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic g_i,
  output logic q_o
);

  (* dont_touch = "true" *) logic latch_q;
  (* dont_touch = "true" *) logic latch_qn;

`ifdef SYNTHESIS
  // G=0 forces both outputs high; releasing G lets the latch race to a random state.
  assign latch_q  = ~(g_i & latch_qn);
  assign latch_qn = ~(g_i & latch_q);
`else
  // Loop-free stand-in for simulation; the bench overrides latch_q directly.
  assign latch_qn = ~g_i;
  assign latch_q  = ~(g_i & latch_qn);
`endif

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], latch_q};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/snpu_trng_harvester.sv
// Entropy harvester: periodic cell excitation, XOR fold, optional von Neumann debias,
// repetition health test and word packing onto a valid/ready port.
module snpu_trng_harvester
  import snpu_trng_pkg::*;
#(
  parameter int N_SRC       = N_SRC_DEF,
  parameter int OUT_W       = OUT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int SAMPLE_DIV  = SAMPLE_DIV_DEF,
  parameter int REP_LIMIT   = REP_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             raw_mode,
  input  logic             clr_fail,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [OUT_W-1:0] rd_data,
  output logic             health_fail,
  output logic [N_SRC-1:0] raw_bits
);

  localparam int DIV_W = cnt_w(SAMPLE_DIV);
  localparam int BIT_W = cnt_w(OUT_W + 1);
  localparam int REP_W = cnt_w(REP_LIMIT + 1);

  trng_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [OUT_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [OUT_W-1:0] word_q, word_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             last_b_q, last_b_d;
  logic             have_last_q, have_last_d;
  logic             health_fail_q, health_fail_d;
  logic             pair_q, pair_d;
  logic             first_q, first_d;
  logic             raw_mode_q;

  logic             cell_g;
  logic             strobe;
  logic             raw_b;
  logic             sample_ok;
  logic             fail_evt;
  logic             accept;
  logic             acc_bit;
  logic             hs;
  logic [OUT_W-1:0] sh_n;
  logic [BIT_W-1:0] cnt_n;

  // ---------------------------------------------------------------- cells
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_cell
    snpu_entropy_cell #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .g_i  (cell_g),
      .q_o  (raw_bits[gi])
    );
  end

  // ---------------------------------------------------------------- sample timing
  always_comb begin
    div_cnt_d = '0;
    if (en) begin
      div_cnt_d = (div_cnt_q == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_cnt_q + 1'b1;
    end
  end

  // Cells race in the first cycle of each period; the synchroniser settles before the strobe.
  assign cell_g    = ~(en & (div_cnt_q == '0));
  assign strobe    = en & (div_cnt_q == DIV_W'(SAMPLE_DIV - 1));
  assign raw_b     = ^raw_bits;
  assign sample_ok = strobe & (state_q != FAIL);
  assign fail_evt  = (rep_cnt_q == REP_W'(REP_LIMIT)) & ~health_fail_q;

  // ---------------------------------------------------------------- repetition test
  always_comb begin
    rep_cnt_d     = rep_cnt_q;
    last_b_d      = last_b_q;
    have_last_d   = have_last_q;
    health_fail_d = health_fail_q;
    if (sample_ok) begin
      if (have_last_q && (raw_b == last_b_q)) begin
        if (rep_cnt_q != REP_W'(REP_LIMIT)) begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end else begin
        rep_cnt_d = REP_W'(1);
      end
      last_b_d    = raw_b;
      have_last_d = 1'b1;
    end
    // A failure in the same cycle as clr_fail must survive.
    if (fail_evt) begin
      health_fail_d = 1'b1;
    end else if (clr_fail) begin
      health_fail_d = 1'b0;
      rep_cnt_d     = '0;
      have_last_d   = 1'b0;
    end
  end

  // ---------------------------------------------------------------- debiaser
  always_comb begin
    pair_d  = pair_q;
    first_d = first_q;
    accept  = 1'b0;
    acc_bit = raw_b;
    if (sample_ok) begin
      if (raw_mode) begin
        accept = 1'b1;
      end else if (!pair_q) begin
        first_d = raw_b;
        pair_d  = 1'b1;
      end else begin
        pair_d  = 1'b0;
        accept  = first_q ^ raw_b;
        acc_bit = first_q;
      end
    end
    if (!en || (raw_mode != raw_mode_q) || clr_fail) begin
      pair_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------- packer FSM
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    word_d    = word_q;
    rd_valid  = (state_q == FULL);
    hs        = rd_valid & rd_ready;

    // Bits arriving once the shift register is full are dropped.
    sh_n  = shift_q;
    cnt_n = bit_cnt_q;
    if (accept && (bit_cnt_q != BIT_W'(OUT_W)) && ((state_q == FILL) || (state_q == FULL))) begin
      sh_n  = {shift_q[OUT_W-2:0], acc_bit};
      cnt_n = bit_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (!en) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else if (cnt_n == BIT_W'(OUT_W)) begin
          word_d    = sh_n;
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = FULL;
        end else begin
          shift_d   = sh_n;
          bit_cnt_d = cnt_n;
        end
      end
      FULL: begin
        if (!en) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          if (hs) begin
            state_d = IDLE;
          end
        end else if (hs && (cnt_n == BIT_W'(OUT_W))) begin
          word_d    = sh_n;
          shift_d   = '0;
          bit_cnt_d = '0;
        end else begin
          shift_d   = sh_n;
          bit_cnt_d = cnt_n;
          if (hs) begin
            state_d = FILL;
          end
        end
      end
      FAIL: begin
        shift_d   = '0;
        bit_cnt_d = '0;
        if (clr_fail) begin
          state_d = en ? FILL : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (fail_evt) begin
      state_d   = FAIL;
      shift_d   = '0;
      bit_cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------- state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      div_cnt_q     <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      word_q        <= '0;
      rep_cnt_q     <= '0;
      last_b_q      <= 1'b0;
      have_last_q   <= 1'b0;
      health_fail_q <= 1'b0;
      pair_q        <= 1'b0;
      first_q       <= 1'b0;
      raw_mode_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      word_q        <= word_d;
      rep_cnt_q     <= rep_cnt_d;
      last_b_q      <= last_b_d;
      have_last_q   <= have_last_d;
      health_fail_q <= health_fail_d;
      pair_q        <= pair_d;
      first_q       <= first_d;
      raw_mode_q    <= raw_mode;
    end
  end

  assign rd_data     = word_q;
  assign health_fail = health_fail_q;

endmodule

// File: tb/tb_snpu_trng_harvester.sv
// Directed bench for snpu_trng_harvester: forces the cell latch nodes to set each folded sample.
module tb_snpu_trng_harvester;

  localparam int N_SRC      = 8;
  localparam int OUT_W      = 8;
  localparam int SAMPLE_DIV = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             raw_mode;
  logic             clr_fail;
  logic             rd_ready;
  logic             rd_valid;
  logic [OUT_W-1:0] rd_data;
  logic             health_fail;
  logic [N_SRC-1:0] raw_bits;
  logic [N_SRC-1:0] cell_vec = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  snpu_trng_harvester #(
    .N_SRC      (N_SRC),
    .OUT_W      (OUT_W),
    .SYNC_STAGES(2),
    .SAMPLE_DIV (SAMPLE_DIV),
    .REP_LIMIT  (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .raw_mode   (raw_mode),
    .clr_fail   (clr_fail),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .health_fail(health_fail),
    .raw_bits   (raw_bits)
  );

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_force
    initial begin
      force dut.g_cell[gi].u_cell.latch_q = 1'b0;
      forever begin
        @(cell_vec);
        force dut.g_cell[gi].u_cell.latch_q = cell_vec[gi];
      end
    end
  end

  // Scatter a pattern over all cells whose XOR equals b.
  task automatic set_cells(input logic b);
    logic [N_SRC-1:0] v;
    v = N_SRC'($urandom);
    v[0] = v[0] ^ (^v) ^ b;
    cell_vec = v;
  endtask

  task automatic send_bit(input logic b);
    set_cells(b);
    repeat (SAMPLE_DIV) @(negedge clk);
  endtask

  task automatic send_word(input logic [OUT_W-1:0] w);
    for (int i = OUT_W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic pulse_clr();
    clr_fail = 1'b1;
    @(negedge clk);
    clr_fail = 1'b0;
  endtask

  task automatic drain_idle(input string tag);
    en       = 1'b0;
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: rd_valid=%b expected 0", tag, rd_valid);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: rd_valid=%b expected 0", rd_valid); end
    n_checks++;
    if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: rd_data=%h expected 00", rd_data); end
    n_checks++;
    if (health_fail !== 1'b0) begin n_fail++; $display("FAIL rst_health: health_fail=%b expected 0", health_fail); end
    n_checks++;
    if (raw_bits !== 8'h00) begin n_fail++; $display("FAIL rst_raw: raw_bits=%h expected 00", raw_bits); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dut.state_q !== snpu_trng_pkg::IDLE) begin n_fail++; $display("FAIL rst_state: state=%0d expected IDLE", dut.state_q); end
    $display("reset released, state idle");
  endtask

  task automatic test_raw_word();
    logic [OUT_W-1:0] w;
    w        = 8'hB2;
    raw_mode = 1'b1;
    en       = 1'b1;
    for (int i = OUT_W - 1; i >= 1; i--) send_bit(w[i]);
    set_cells(w[0]);
    repeat (SAMPLE_DIV - 1) @(negedge clk);
    n_checks++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL raw_early: rd_valid=%b expected 0 before 8th strobe", rd_valid); end
    n_checks++;
    if (raw_bits !== cell_vec) begin n_fail++; $display("FAIL raw_bits: raw_bits=%h expected %h", raw_bits, cell_vec); end
    @(negedge clk);
    n_checks++;
    if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL raw_valid: rd_valid=%b expected 1", rd_valid); end
    n_checks++;
    if (rd_data !== 8'hB2) begin n_fail++; $display("FAIL raw_data: rd_data=%h expected b2", rd_data); end
    $display("raw-mode word offered data=%h", rd_data);
  endtask

  task automatic test_reset_mid_full();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: rd_valid=%b expected 0", rd_valid); end
    n_checks++;
    if (rd_data !== 8'h00) begin n_fail++; $display("FAIL arst_data: rd_data=%h expected 00", rd_data); end
    n_checks++;
    if (health_fail !== 1'b0) begin n_fail++; $display("FAIL arst_health: health_fail=%b expected 0", health_fail); end
    n_checks++;
    if (raw_bits !== 8'h00) begin n_fail++; $display("FAIL arst_raw: raw_bits=%h expected 00", raw_bits); end
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dut.state_q !== snpu_trng_pkg::IDLE) begin n_fail++; $display("FAIL arst_state: state=%0d expected IDLE", dut.state_q); end
    $display("reset during full word, state idle after release");
  endtask

  task automatic test_debias();
    logic [19:0] s;
    s        = 20'b0110_0011_1010_0101_1001;
    raw_mode = 1'b0;
    en       = 1'b1;
    for (int i = 19; i >= 2; i--) send_bit(s[i]);
    n_checks++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL vn_early: rd_valid=%b expected 0 after 7 accepted bits", rd_valid); end
    send_bit(s[1]);
    send_bit(s[0]);
    n_checks++;
    if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL vn_valid: rd_valid=%b expected 1", rd_valid); end
    n_checks++;
    if (rd_data !== 8'h72) begin n_fail++; $display("FAIL vn_data: rd_data=%h expected 72", rd_data); end
    $display("debiased word offered data=%h", rd_data);
    drain_idle("vn");
  endtask

  task automatic test_health();
    pulse_clr();
    raw_mode = 1'b1;
    en       = 1'b1;
    for (int i = 0; i < 16; i++) send_bit(1'b1);
    n_checks++;
    if (health_fail !== 1'b0) begin n_fail++; $display("FAIL hlth_early: health_fail=%b expected 0", health_fail); end
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hFF) begin
      n_fail++; $display("FAIL hlth_word: valid=%b data=%h expected 1/ff", rd_valid, rd_data);
    end
    @(negedge clk);
    n_checks++;
    if (health_fail !== 1'b1) begin n_fail++; $display("FAIL hlth_trip: health_fail=%b expected 1", health_fail); end
    n_checks++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL hlth_valid: rd_valid=%b expected 0", rd_valid); end
    en = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (health_fail !== 1'b1) begin n_fail++; $display("FAIL hlth_sticky: health_fail=%b expected 1", health_fail); end
    pulse_clr();
    n_checks++;
    if (health_fail !== 1'b0) begin n_fail++; $display("FAIL hlth_clr: health_fail=%b expected 0", health_fail); end
    n_checks++;
    if (dut.state_q !== snpu_trng_pkg::IDLE) begin n_fail++; $display("FAIL hlth_state: state=%0d expected IDLE", dut.state_q); end
    en = 1'b1;
    send_word(8'h5A);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin
      n_fail++; $display("FAIL hlth_recover: valid=%b data=%h expected 1/5a", rd_valid, rd_data);
    end
    $display("post-clear word offered data=%h", rd_data);
    drain_idle("hlth");
  endtask

  task automatic test_back_to_back();
    pulse_clr();
    raw_mode = 1'b1;
    rd_ready = 1'b0;
    en       = 1'b1;
    send_word(8'h3C);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin
      n_fail++; $display("FAIL b2b_first: valid=%b data=%h expected 1/3c", rd_valid, rd_data);
    end
    send_word(8'hC3);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin
      n_fail++; $display("FAIL b2b_hold: valid=%b data=%h expected 1/3c", rd_valid, rd_data);
    end
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    $display("word accepted data=3c");
    n_checks++;
    if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: rd_valid=%b expected 1", rd_valid); end
    n_checks++;
    if (rd_data !== 8'hC3) begin n_fail++; $display("FAIL b2b_second: rd_data=%h expected c3", rd_data); end
    $display("second word offered data=%h", rd_data);
    drain_idle("b2b");
  endtask

  task automatic test_en_drop();
    pulse_clr();
    raw_mode = 1'b1;
    en       = 1'b1;
    send_word(8'h96);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h96) begin
      n_fail++; $display("FAIL drop_word: valid=%b data=%h expected 1/96", rd_valid, rd_data);
    end
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    n_checks++;
    if (dut.bit_cnt_q !== 4'd5) begin n_fail++; $display("FAIL drop_partial: bit_cnt=%0d expected 5", dut.bit_cnt_q); end
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_cells(i[0]);
      @(negedge clk);
    end
    n_checks++;
    if (dut.bit_cnt_q !== 4'd0) begin n_fail++; $display("FAIL drop_cleared: bit_cnt=%0d expected 0", dut.bit_cnt_q); end
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h96) begin
      n_fail++; $display("FAIL drop_kept: valid=%b data=%h expected 1/96", rd_valid, rd_data);
    end
    en = 1'b1;
    send_word(8'h0F);
    n_checks++;
    if (rd_data !== 8'h96) begin n_fail++; $display("FAIL drop_pending: rd_data=%h expected 96", rd_data); end
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    $display("word accepted data=96");
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h0F) begin
      n_fail++; $display("FAIL drop_resume: valid=%b data=%h expected 1/0f", rd_valid, rd_data);
    end
    $display("resumed word offered data=%h", rd_data);
    drain_idle("drop");
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    raw_mode = 1'b0;
    clr_fail = 1'b0;
    rd_ready = 1'b0;
    test_reset();
    test_raw_word();
    test_reset_mid_full();
    test_debias();
    test_health();
    test_back_to_back();
    test_en_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
